// File: rtl/rf_cmd_ctrl.sv
// Byte-stream command decoder for a register file: 0xAA addr data writes, 0xBB addr reads
// and forwards the result to a transmitter. All outputs are registered.
module rf_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Rx_Data,
  input  logic                  Rx_Valid,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_valid,
  input  logic                  Tx_Busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] Tx_Data,
  output logic                  Tx_Valid,
  output logic                  Cmd_Err
);

  localparam int CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]         TO_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] OP_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD   = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_REQ, RD_WAIT, TX_SEND
  } state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      to_cnt   <= '0;
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      Tx_Valid <= 1'b0;
      Cmd_Err  <= 1'b0;
      Address  <= '0;
      WrData   <= '0;
      Tx_Data  <= '0;
    end else begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      Tx_Valid <= 1'b0;
      Cmd_Err  <= 1'b0;
      // Bytes arriving while a read is in flight are discarded and flagged.
      if (Rx_Valid && (state == RD_REQ || state == RD_WAIT || state == TX_SEND))
        Cmd_Err <= 1'b1;
      case (state)
        IDLE: if (Rx_Valid) begin
          if (Rx_Data == OP_WR)      state <= WR_ADDR;
          else if (Rx_Data == OP_RD) state <= RD_ADDR;
          else                       Cmd_Err <= 1'b1;
        end
        WR_ADDR: if (Rx_Valid) begin
          Address <= Rx_Data[ADDR_WIDTH-1:0];
          state   <= WR_DATA;
        end
        WR_DATA: if (Rx_Valid) begin
          WrData <= Rx_Data;
          WrEn   <= 1'b1;
          state  <= IDLE;
        end
        RD_ADDR: if (Rx_Valid) begin
          Address <= Rx_Data[ADDR_WIDTH-1:0];
          state   <= RD_REQ;
        end
        RD_REQ: begin
          RdEn   <= 1'b1;
          to_cnt <= '0;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (RdData_valid) begin
            Tx_Data <= RdData;
            state   <= TX_SEND;
          end else if (to_cnt == TO_LAST) begin
            Cmd_Err <= 1'b1;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        TX_SEND: if (!Tx_Busy) begin
          Tx_Valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
